// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill path.
package cache_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int DC_BLOCK_WORDS = 2;
  localparam int IC_BLOCK_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } refill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count enabled events, holding once every bit is set
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {W{1'b0}};
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1'b1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: fetches one cache block word by word from memory
// and hands the assembled block to the cache with a one-cycle dready pulse.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int BLOCK_WORDS = DC_BLOCK_WORDS,
  parameter int CNT_W       = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          miss_req,
  input  logic [ADDR_W-1:0]             miss_addr,
  output logic                          busy,
  output logic [WORD_W*BLOCK_WORDS-1:0] datain,
  output logic                          dready,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  input  logic [WORD_W-1:0]             mem_rdata,
  output logic [CNT_W-1:0]              refill_count
);

  localparam int OFF = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'((1 << (OFF + 2)) - 1);
  localparam logic [OFF-1:0]    LAST_WIDX = OFF'(BLOCK_WORDS - 1);

  refill_state_t                 r_state, w_state_nxt;
  logic [ADDR_W-1:0]             r_base, w_base_nxt;
  logic [OFF-1:0]                r_widx, w_widx_nxt;
  logic                          w_word_wr;
  logic                          w_cnt_en;
  logic [WORD_W*BLOCK_WORDS-1:0] r_datain;
  logic                          r_busy;
  logic                          r_dready;
  logic                          r_mem_req;
  logic [ADDR_W-1:0]             r_mem_addr;

  // Next-state, base latch and word-index advance
  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_widx_nxt  = r_widx;
    w_word_wr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss_req) begin
          w_state_nxt = REQ;
          w_base_nxt  = miss_addr & ~OFS_MASK;
          w_widx_nxt  = {OFF{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          w_word_wr = 1'b1;
          if (r_widx == LAST_WIDX) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = REQ;
            w_widx_nxt  = r_widx + OFF'(1'b1);
          end
        end else begin
          w_state_nxt = WAIT;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, block base and word index registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_base  <= {ADDR_W{1'b0}};
      r_widx  <= {OFF{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_base  <= w_base_nxt;
      r_widx  <= w_widx_nxt;
    end
  end

  // Outputs registered from the next state so they track the state exactly
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy     <= 1'b0;
      r_dready   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= {ADDR_W{1'b0}};
    end else begin
      r_busy    <= (w_state_nxt != IDLE);
      r_dready  <= (w_state_nxt == DONE);
      r_mem_req <= (w_state_nxt == REQ);
      if (w_state_nxt == REQ) begin
        r_mem_addr <= w_base_nxt | {{(ADDR_W-OFF-2){1'b0}}, w_widx_nxt, 2'b00};
      end else begin
        r_mem_addr <= r_mem_addr;
      end
    end
  end

  // Each returned word goes to its slot; word 0 occupies the top bits
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_datain <= {(WORD_W*BLOCK_WORDS){1'b0}};
    end else begin
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        if (w_word_wr && (r_widx == OFF'(i))) begin
          r_datain[WORD_W*(BLOCK_WORDS-i)-1 -: WORD_W] <= mem_rdata;
        end
      end
    end
  end

  assign w_cnt_en = (r_state == DONE);

  sat_counter #(
    .W(CNT_W)
  ) u_refill_cnt (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_en    (w_cnt_en),
    .o_count (refill_count)
  );

  assign busy     = r_busy;
  assign datain   = r_datain;
  assign dready   = r_dready;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: a 2-word instance with a 2-bit
// counter and a 4-word instance, each with its own memory responder.
module tb_cache_refill_ctrl;

  typedef struct {
    logic [127:0] data;
    int           cyc;
    logic [31:0]  cnt;
  } exp_t;

  logic         CLK;
  logic         RESET;
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           a_reads = 0;
  int           ack_dly = 0;
  int           rv_dly = 0;

  logic         a_miss_req, a_busy, a_dready, a_mem_req, a_mem_ack, a_mem_rvalid;
  logic [31:0]  a_miss_addr, a_mem_addr, a_mem_rdata;
  logic [63:0]  a_datain;
  logic [1:0]   a_refill_count;

  logic         b_miss_req, b_busy, b_dready, b_mem_req, b_mem_ack, b_mem_rvalid;
  logic [31:0]  b_miss_addr, b_mem_addr, b_mem_rdata;
  logic [127:0] b_datain;
  logic [31:0]  b_refill_count;

  exp_t         a_exp_q[$];
  exp_t         b_exp_q[$];
  logic [31:0]  a_addr_q[$];
  logic [31:0]  a_data_q[$];
  logic [31:0]  b_addr_q[$];
  logic [31:0]  b_data_q[$];

  cache_refill_ctrl #(.BLOCK_WORDS(2), .CNT_W(2)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .miss_req(a_miss_req), .miss_addr(a_miss_addr),
    .busy(a_busy), .datain(a_datain), .dready(a_dready), .mem_req(a_mem_req),
    .mem_addr(a_mem_addr), .mem_ack(a_mem_ack), .mem_rvalid(a_mem_rvalid),
    .mem_rdata(a_mem_rdata), .refill_count(a_refill_count)
  );

  cache_refill_ctrl #(.BLOCK_WORDS(4), .CNT_W(32)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .miss_req(b_miss_req), .miss_addr(b_miss_addr),
    .busy(b_busy), .datain(b_datain), .dready(b_dready), .mem_req(b_mem_req),
    .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_rvalid(b_mem_rvalid),
    .mem_rdata(b_mem_rdata), .refill_count(b_refill_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Instance A memory: configurable ack and rvalid wait cycles
  initial begin
    logic [31:0] exp_addr;
    a_mem_ack = 1'b0; a_mem_rvalid = 1'b0; a_mem_rdata = 32'h0;
    forever begin
      if (a_mem_req === 1'b1 && RESET === 1'b0) begin
        if (a_addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a_unexpected_read: actual addr %h required no read", a_mem_addr);
          @(posedge CLK); #1;
        end else begin
          exp_addr = a_addr_q.pop_front();
          check("a_mem_addr", 128'(a_mem_addr), 128'(exp_addr));
          for (int i = 0; i < ack_dly; i++) begin
            @(posedge CLK); #1;
            check("a_req_hold", 128'({a_mem_req, a_mem_addr}), 128'({1'b1, exp_addr}));
          end
          a_mem_ack = 1'b1;
          @(posedge CLK); #1;
          a_mem_ack = 1'b0;
          for (int i = 0; i < rv_dly; i++) begin
            @(posedge CLK); #1;
          end
          a_mem_rvalid = 1'b1;
          a_mem_rdata  = (a_data_q.size() != 0) ? a_data_q.pop_front() : 32'hDEAD_DEAD;
          @(posedge CLK); #1;
          a_mem_rvalid = 1'b0;
          a_reads++;
        end
      end else begin
        @(posedge CLK); #1;
      end
    end
  end

  // Instance B memory: zero-wait ack and data
  initial begin
    b_mem_ack = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = 32'h0;
    forever begin
      @(posedge CLK); #1;
      b_mem_rvalid = b_mem_ack;
      if (b_mem_ack === 1'b1) b_mem_rdata = (b_data_q.size() != 0) ? b_data_q.pop_front() : 32'hDEAD_DEAD;
      b_mem_ack = (b_mem_req === 1'b1);
      if (b_mem_req === 1'b1) begin
        if (b_addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b_unexpected_read: actual addr %h required no read", b_mem_addr);
        end else begin
          check("b_mem_addr", 128'(b_mem_addr), 128'(b_addr_q.pop_front()));
        end
      end
    end
  end

  // Monitors: pop the scoreboard on each dready pulse
  always begin
    exp_t e;
    @(negedge CLK);
    if (a_dready === 1'b1) begin
      if (a_exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected_dready: actual 1 in cycle %0d required 0", cyc);
      end else begin
        e = a_exp_q.pop_front();
        check("a_datain", 128'(a_datain), e.data);
        check("a_dready_cycle", 128'(cyc), 128'(e.cyc));
        @(negedge CLK);
        check("a_dready_pulse", 128'(a_dready), 128'(1'b0));
        check("a_refill_count", 128'(a_refill_count), 128'(e.cnt));
      end
    end
  end

  always begin
    exp_t e;
    @(negedge CLK);
    if (b_dready === 1'b1) begin
      if (b_exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected_dready: actual 1 in cycle %0d required 0", cyc);
      end else begin
        e = b_exp_q.pop_front();
        check("b_datain", b_datain, e.data);
        check("b_dready_cycle", 128'(cyc), 128'(e.cyc));
        @(negedge CLK);
        check("b_refill_count", 128'(b_refill_count), 128'(e.cnt));
      end
    end
  end

  // One-cycle miss pulse on instance A; called #1 after a rising edge while idle
  task automatic issue_a(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1,
                         input int lat, input logic [31:0] cnt, input bit expect_done);
    exp_t e;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFF8;
    a_addr_q.push_back(base);
    a_addr_q.push_back(base | 32'h4);
    a_data_q.push_back(w0);
    a_data_q.push_back(w1);
    e.data = {64'h0, w0, w1};
    e.cyc  = cyc + lat;
    e.cnt  = cnt;
    if (expect_done) a_exp_q.push_back(e);
    a_miss_addr = addr;
    a_miss_req  = 1'b1;
    @(posedge CLK); #1;
    a_miss_req  = 1'b0;
  endtask

  task automatic wait_idle(input bit use_b, input string name);
    int n = 0;
    while (n < 200 && (use_b ? (b_busy || b_exp_q.size() != 0) : (a_busy || a_exp_q.size() != 0))) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: actual busy after %0d cycles required idle", name, n);
    end
    repeat (3) begin
      @(posedge CLK); #1;
    end
    check({name, "_idle"}, 128'(use_b ? b_busy : a_busy), 128'(1'b0));
  endtask

  initial begin
    exp_t e;
    int   c0;
    int   reads0;
    int   seen;
    int   n;
    RESET = 1'b1;
    a_miss_req = 1'b0; a_miss_addr = 32'h0;
    b_miss_req = 1'b0; b_miss_addr = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", 128'(a_busy), 128'(1'b0));
    check("rst_dready", 128'(a_dready), 128'(1'b0));
    check("rst_mem_req", 128'({a_mem_req, b_mem_req}), 128'(2'b00));
    check("rst_mem_addr", 128'(a_mem_addr), 128'(32'h0));
    check("rst_datain", 128'(a_datain), 128'(64'h0));
    check("rst_count", 128'(a_refill_count), 128'(2'd0));
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Zero-wait refill
    ack_dly = 0; rv_dly = 0;
    issue_a(32'h0000_1234, 32'hAAAA_0001, 32'hBBBB_0002, 5, 32'd1, 1'b1);
    wait_idle(1'b0, "zero_wait");

    // Stalled memory: 3 ack waits, 2 rvalid waits per word
    ack_dly = 3; rv_dly = 2;
    issue_a(32'h0000_2008, 32'h1111_1111, 32'h2222_2222, 15, 32'd2, 1'b1);
    for (int i = 0; i < 15; i++) begin
      check("a_busy_stall", 128'(a_busy), 128'(1'b1));
      @(posedge CLK); #1;
    end
    wait_idle(1'b0, "stall");

    // Foreign miss_req pulsed during WAIT must be ignored
    ack_dly = 0; rv_dly = 0;
    reads0 = a_reads;
    issue_a(32'h0000_4444, 32'h3333_0003, 32'h4444_0004, 5, 32'd3, 1'b1);
    @(posedge CLK); #1;
    a_miss_addr = 32'hDEAD_BEE8;
    a_miss_req  = 1'b1;
    @(posedge CLK); #1;
    a_miss_req  = 1'b0;
    wait_idle(1'b0, "ignore_miss");
    check("ignore_read_count", 128'(a_reads - reads0), 128'(2));

    // RESET in WAIT of word 1 after word 0 returned
    ack_dly = 0; rv_dly = 3;
    issue_a(32'h0000_5550, 32'h5555_0005, 32'h6666_0006, 0, 32'd0, 1'b0);
    repeat (7) begin
      @(posedge CLK); #1;
    end
    check("pre_reset_wait", 128'({a_busy, a_mem_req}), 128'(2'b10));
    RESET = 1'b1;
    #1;
    check("abort_busy", 128'(a_busy), 128'(1'b0));
    check("abort_mem_req", 128'(a_mem_req), 128'(1'b0));
    check("abort_mem_addr", 128'(a_mem_addr), 128'(32'h0));
    check("abort_datain", 128'(a_datain), 128'(64'h0));
    check("abort_count", 128'(a_refill_count), 128'(2'd0));
    repeat (4) begin
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Five back-to-back refills with miss_req held; counter saturates at 3
    rv_dly = 0;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      a_addr_q.push_back(32'h0000_5550);
      a_addr_q.push_back(32'h0000_5554);
      a_data_q.push_back(32'h7000_0000 | 32'(k));
      a_data_q.push_back(32'h8000_0000 | 32'(k));
      e.data = {64'h0, 32'h7000_0000 | 32'(k), 32'h8000_0000 | 32'(k)};
      e.cyc  = c0 + 5 + 6 * k;
      e.cnt  = (k < 3) ? 32'(k + 1) : 32'd3;
      a_exp_q.push_back(e);
    end
    a_miss_addr = 32'h0000_5550;
    a_miss_req  = 1'b1;
    seen = 0; n = 0;
    while (seen < 5 && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (a_dready === 1'b1) seen++;
    end
    a_miss_req = 1'b0;
    if (seen < 5) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_timeout: actual %0d dready pulses required 5", seen);
    end
    wait_idle(1'b0, "b2b");

    // Four-word block on instance B
    b_addr_q.push_back(32'h0000_0100);
    b_addr_q.push_back(32'h0000_0104);
    b_addr_q.push_back(32'h0000_0108);
    b_addr_q.push_back(32'h0000_010C);
    for (int k = 0; k < 4; k++) b_data_q.push_back(32'hC0DE_0000 | 32'(k));
    e.data = 128'hC0DE0000_C0DE0001_C0DE0002_C0DE0003;
    e.cyc  = cyc + 9;
    e.cnt  = 32'd1;
    b_exp_q.push_back(e);
    b_miss_addr = 32'h0000_0108;
    b_miss_req  = 1'b1;
    @(posedge CLK); #1;
    b_miss_req  = 1'b0;
    wait_idle(1'b1, "four_word");

    check("a_addr_q_empty", 128'(a_addr_q.size()), 128'(0));
    check("b_addr_q_empty", 128'(b_addr_q.size()), 128'(0));
    check("b_data_q_empty", 128'(b_data_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-refill engine sitting directly upstream of the data cache, between the cache and main memory. On a miss request it latches the block address and issues one 32-bit read per word of the block over a request/acknowledge memory port. It assembles the returned words into one cache block and presents it on `datain`, pulsing `dready` for exactly one cycle so the cache can write the block into its LRU way. The same block serves the instruction cache with `BLOCK_WORDS=4`.

## Interface
- `BLOCK_WORDS`, 2: words per cache block; power of two, 2 or 4. `OFF = log2(BLOCK_WORDS)`.
- `CNT_W`, 32: width of the refill statistics counter.
- `CLK` in 1: single clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `miss_req` in 1: cache requests a refill; sampled only in IDLE.
- `miss_addr` in 32: byte address of the missing access; sampled with `miss_req`.
- `busy` out 1: high whenever state is not IDLE.
- `datain` out 32*BLOCK_WORDS: assembled block; word 0 in the most significant 32 bits.
- `dready` out 1: one-cycle pulse; `datain` is valid in that cycle.
- `mem_req` out 1: read request to memory; held until acknowledged.
- `mem_addr` out 32: word address of the current read.
- `mem_ack` in 1: memory accepts the request.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.
- `refill_count` out CNT_W: number of completed refills; saturates at all-ones.

## Operation
- States:
  - IDLE
  - REQ: `mem_req=1`
  - WAIT: waiting for data
  - DONE: `dready=1`
- IDLE -> REQ when `miss_req=1`:
  - latch `base = miss_addr[31:OFF+2]`
  - clear word index `widx`
- REQ:
  - drive `mem_addr = {base, widx, 2'b00}`
  - stay while `mem_ack=0`
  - on `mem_ack=1` go to WAIT
- WAIT, on `mem_rvalid=1`:
  - store `mem_rdata` into `datain[32*(BLOCK_WORDS-widx)-1 -: 32]`
  - if `widx == BLOCK_WORDS-1`, go to DONE
  - otherwise increment `widx` and go to REQ
- DONE:
  - `dready=1` for one cycle
  - increment `refill_count` unless it is all-ones
  - go to IDLE
- `mem_rvalid` outside WAIT is ignored. Memory guarantees at least one cycle between `mem_ack` and `mem_rvalid`.
- `miss_req` while not in IDLE is ignored. The cache must hold `miss_req` until it sees `dready`; a request still held in the IDLE cycle after DONE starts a new refill.
- `datain` holds its last assembled value after DONE. A new refill overwrites it word by word.
- `mem_addr` is don't-care outside REQ; drive it to the last value.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `widx=0`
  - `datain=0`, `dready=0`, `mem_req=0`, `busy=0`
  - `mem_addr=0`, `refill_count=0`
- RESET asserted mid-refill:
  - refill aborted; partial data discarded
  - no `dready` pulse
  - `mem_req` drops in the same cycle
- Latency with zero-wait memory (`mem_ack` in the first REQ cycle, `mem_rvalid` in the first WAIT cycle):
  - `miss_req` sampled in cycle 0
  - `dready` high in cycle `2*BLOCK_WORDS+1` (cycle 5 for BLOCK_WORDS=2)
- Each `mem_ack` wait cycle or `mem_rvalid` wait cycle adds one cycle.
- All outputs are registered or decoded from state only. No input reaches an output combinationally.
- Address arithmetic: `widx` is OFF bits wide, and its increment never wraps within a refill. The base is never incremented, so refills never cross a block boundary.

## Structure
- Shared package `cache_pkg`:
  - state enum `refill_state_t` {IDLE, REQ, WAIT, DONE}
  - `WORD_W=32`, `ADDR_W=32`
  - `DC_BLOCK_WORDS=2`, `IC_BLOCK_WORDS=4`
- One sub-module, `sat_counter`: parameterised width, increment enable, asynchronous active-high reset, holds at all-ones. Instantiated for `refill_count`.
- Everything else lives in `cache_refill_ctrl`.

## Test plan
- Zero-wait refill, BLOCK_WORDS=2, `miss_addr=0x0000_1234`, memory returns 0xAAAA_0001 then 0xBBBB_0002:
  - `mem_addr` sequence 0x0000_1230, 0x0000_1234
  - `dready` in cycle 5 with `datain=0xAAAA0001_BBBB0002`
  - `refill_count=1`
- Stalled memory, `mem_ack` delayed 3 cycles and `mem_rvalid` delayed 2 cycles per word:
  - `mem_req` held steady with a stable address
  - `dready` in cycle 15
  - `busy` high throughout
- Second `miss_req` with `miss_addr=0xDEAD_BEE8` pulsed during WAIT:
  - ignored; the refill completes with the original base
  - no extra memory reads
- RESET asserted in WAIT after word 0 returns:
  - all outputs at reset values immediately; no `dready`
  - the next refill produces correct data with no stale word 0
- BLOCK_WORDS=4, `miss_addr=0x0000_0108`:
  - reads 0x100, 0x104, 0x108, 0x10C
  - `dready` in cycle 9; word 0 in `datain[127:96]`
- `CNT_W=2`, five back-to-back refills:
  - `refill_count` reads 1, 2, 3, 3, 3
